// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the SISO shift-register sequencer.
package siso_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned MaxWidth     = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Bit 'index' of a width-bit word, counted from the end that is sent first.
    function automatic logic bit_sel(input logic [MaxWidth-1:0] word,
                                     input int unsigned         index,
                                     input bit                  msb_first,
                                     input int unsigned         width);
        logic [4:0] pos;
        if (msb_first) begin
            pos = 5'(width - 1 - index);
        end else begin
            pos = 5'(index);
        end
        return word[pos];
    endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// Loadable up-counter for the global shift-cycle index, with terminal-count
// flags at the last data bit (WIDTH-1) and the last flush cycle (WIDTH+DEPTH-1).
module siso_bit_counter
    import siso_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned CntW  = $clog2(WIDTH + DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [CntW-1:0] count_o,
    output logic            tc_word_o,
    output logic            tc_total_o
);

    localparam logic [CntW-1:0] TcWord  = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] TcTotal = CntW'(WIDTH + DEPTH - 1);

    logic [CntW-1:0] count_q, count_d;

    // Clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign tc_word_o  = (count_q == TcWord);
    assign tc_total_o = (count_q == TcTotal);

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer for a DEPTH-stage serial-in/serial-out shift register: accepts a
// parallel word, shifts it in, flushes the pipeline and reassembles the bits
// returned on Serial_OUT. All outputs are registered.
// Optional: define SISO_LOOPBACK_CHECK_EN to add the Mismatch/Error ports that
// compare the returned word against the word that was sent.
module siso_shift_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] Tx_Data,
    input  logic             Tx_Valid,
    output logic             Tx_Ready,
    output logic             Serial_IN,
    output logic             Load,
    input  logic             Serial_OUT,
    output logic [WIDTH-1:0] Rx_Data,
    output logic             Rx_Valid,
    output logic             Busy
`ifdef SISO_LOOPBACK_CHECK_EN
    ,
    output logic             Mismatch,
    output logic             Error
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + DEPTH + 1);

    state_e           state_q, state_d;
    logic             tx_ready_q, load_q, busy_q, serial_in_q, rx_valid_q;
    logic             serial_in_d, shifting_d;
    logic [WIDTH-1:0] tx_word_q, tx_word_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             accept, capture, cnt_clr, cnt_en;
    logic [CntW-1:0]  count;
    logic             tc_word, tc_total;

    assign accept  = Tx_Valid && tx_ready_q;
    assign cnt_en  = (state_q == StShift) || (state_q == StFlush);
    assign cnt_clr = accept || (state_q == StDone);
    // Samples before g = DEPTH are stale register contents.
    assign capture = cnt_en && (32'(count) >= DEPTH);

    siso_bit_counter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CntW  (CntW)
    ) u_bit_counter (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .count_o    (count),
        .tc_word_o  (tc_word),
        .tc_total_o (tc_total)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (tc_word) state_d = StFlush;
            StFlush: if (tc_total) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        shifting_d  = (state_d == StShift) || (state_d == StFlush);
        tx_word_d   = accept ? Tx_Data : tx_word_q;
        serial_in_d = 1'b0;
        if (accept) begin
            serial_in_d = bit_sel(MaxWidth'(Tx_Data), 0, MSB_FIRST, WIDTH);
        end else if ((state_q == StShift) && !tc_word) begin
            serial_in_d = bit_sel(MaxWidth'(tx_word_q), 32'(count) + 1, MSB_FIRST, WIDTH);
        end
        rx_sr_d = rx_sr_q;
        if (capture) begin
            if (MSB_FIRST) begin
                rx_sr_d = WIDTH'({rx_sr_q, Serial_OUT});
            end else begin
                rx_sr_d = WIDTH'({Serial_OUT, rx_sr_q} >> 1);
            end
        end
        rx_data_d = (state_d == StDone) ? rx_sr_d : rx_data_q;
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            tx_ready_q  <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            serial_in_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_word_q   <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_ready_q  <= (state_d == StIdle);
            load_q      <= shifting_d;
            busy_q      <= shifting_d;
            serial_in_q <= serial_in_d;
            rx_valid_q  <= (state_d == StDone);
            tx_word_q   <= tx_word_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign Tx_Ready  = tx_ready_q;
    assign Load      = load_q;
    assign Busy      = busy_q;
    assign Serial_IN = serial_in_q;
    assign Rx_Valid  = rx_valid_q;
    assign Rx_Data   = rx_data_q;

`ifdef SISO_LOOPBACK_CHECK_EN
    logic mismatch_q, mismatch_d, error_q, error_d;

    // Compare the reassembled word against the sent word as it is presented.
    always_comb begin
        mismatch_d = (state_d == StDone) && (rx_sr_d != tx_word_q);
        error_d    = error_q || mismatch_d;
    end

    // Mismatch pulses with Rx_Valid; Error is sticky until reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mismatch_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
            error_q    <= error_d;
        end
    end

    assign Mismatch = mismatch_q;
    assign Error    = error_q;
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: one MSB-first and one LSB-first instance, each
// driving a behavioural 4-stage shift register model.
module tb_siso_shift_ctrl;

    logic            CLK;
    logic            RST_N;
    logic [1:0][7:0] tx_data;
    logic [1:0]      tx_valid;
    logic [1:0]      tx_ready;
    logic [1:0]      serial_in;
    logic [1:0]      load;
    logic [1:0]      sout;
    logic [1:0][7:0] rx_data;
    logic [1:0]      rx_valid;
    logic [1:0]      busy;
    logic [1:0][3:0] sr;
    logic [1:0]      preload;
    logic [1:0]      stuck;
`ifdef SISO_LOOPBACK_CHECK_EN
    logic [1:0]      mismatch;
    logic [1:0]      error;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    siso_shift_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Tx_Data    (tx_data[0]),
        .Tx_Valid   (tx_valid[0]),
        .Tx_Ready   (tx_ready[0]),
        .Serial_IN  (serial_in[0]),
        .Load       (load[0]),
        .Serial_OUT (sout[0]),
        .Rx_Data    (rx_data[0]),
        .Rx_Valid   (rx_valid[0]),
        .Busy       (busy[0])
`ifdef SISO_LOOPBACK_CHECK_EN
        ,
        .Mismatch   (mismatch[0]),
        .Error      (error[0])
`endif
    );

    siso_shift_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Tx_Data    (tx_data[1]),
        .Tx_Valid   (tx_valid[1]),
        .Tx_Ready   (tx_ready[1]),
        .Serial_IN  (serial_in[1]),
        .Load       (load[1]),
        .Serial_OUT (sout[1]),
        .Rx_Data    (rx_data[1]),
        .Rx_Valid   (rx_valid[1]),
        .Busy       (busy[1])
`ifdef SISO_LOOPBACK_CHECK_EN
        ,
        .Mismatch   (mismatch[1]),
        .Error      (error[1])
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural 4-stage shift register per instance; not reset.
    always_ff @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (preload[d]) begin
                sr[d] <= 4'b1111;
            end else if (load[d]) begin
                sr[d] <= {sr[d][2:0], serial_in[d]};
            end
        end
    end

    assign sout = {sr[1][3] | stuck[1], sr[0][3] | stuck[0]};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send one word and return in the Rx_Valid cycle; lat counts cycles after the accept edge.
    task automatic run_word(input int d, input logic [7:0] w, output logic [7:0] got,
                            output int lat);
        int n;
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        n = 0;
        while (!tx_ready[d] && n < 20) begin
            tick();
            n++;
        end
        check_eq("accept_wait", 32'(tx_ready[d]), 32'd1);
        tick();
        tx_valid[d] = 1'b0;
        lat = 1;
        while (!rx_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
        got = rx_data[d];
    endtask

    initial begin
        logic [11:0] exp_a5;
        logic [7:0]  exp_3c;
        logic [7:0]  got;
        int          lat;
        int          pulses;

        RST_N    = 1'b0;
        tx_data  = '0;
        tx_valid = '0;
        preload  = '0;
        stuck    = '0;
        exp_a5   = 12'b1010_0101_0000;
        exp_3c   = 8'h3C;

        // Reset held for three cycles.
        tick();
        tick();
        check_eq("rst_ctrl", 32'({tx_ready, load, serial_in, rx_valid, busy}), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();
        check_eq("ready_after_rst", 32'(tx_ready), 32'b11);

        // MSB-first 8'hA5.
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        check_eq("a5_busy_ready", 32'({busy[0], tx_ready[0]}), 32'b10);
        for (int g = 0; g < 12; g++) begin
            check_eq("a5_load", 32'(load[0]), 32'd1);
            check_eq("a5_serial_in", 32'(serial_in[0]), 32'(exp_a5[11-g]));
            check_eq("a5_no_rx_valid", 32'(rx_valid[0]), 32'd0);
            tick();
        end
        check_eq("a5_rx_valid", 32'(rx_valid[0]), 32'd1);
        check_eq("a5_rx_data", 32'(rx_data[0]), 32'hA5);
        check_eq("a5_done_load_busy", 32'({load[0], busy[0]}), 32'd0);
        tick();
        check_eq("a5_rx_valid_pulse", 32'(rx_valid[0]), 32'd0);
        check_eq("a5_rx_data_hold", 32'(rx_data[0]), 32'hA5);
        check_eq("a5_idle_ready", 32'(tx_ready[0]), 32'd1);

        // LSB-first back-to-back 8'h3C then 8'hF0 with Tx_Valid held.
        tx_data[1]  = 8'h3C;
        tx_valid[1] = 1'b1;
        tick();
        for (int g = 0; g < 8; g++) begin
            check_eq("3c_serial_in", 32'(serial_in[1]), 32'(exp_3c[g]));
            if (g == 0) tx_data[1] = 8'hF0;
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            check_eq("3c_flush_serial_in", 32'(serial_in[1]), 32'd0);
            tick();
        end
        check_eq("3c_rx_valid", 32'(rx_valid[1]), 32'd1);
        check_eq("3c_rx_data", 32'(rx_data[1]), 32'h3C);
        tick();
        check_eq("b2b_idle_ready", 32'(tx_ready[1]), 32'd1);
        tick();
        check_eq("b2b_accept", 32'({busy[1], tx_ready[1]}), 32'b10);
        tx_valid[1] = 1'b0;
        lat = 1;
        while (!rx_valid[1] && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("f0_latency", 32'(lat), 32'd13);
        check_eq("f0_rx_data", 32'(rx_data[1]), 32'hF0);

        // Stale register contents must be ignored.
        tick();
        preload[0] = 1'b1;
        tick();
        preload[0] = 1'b0;
        run_word(0, 8'h00, got, lat);
        check_eq("stale_latency", 32'(lat), 32'd13);
        check_eq("stale_rx_data", 32'(got), 32'h00);

        // Reset in SHIFT cycle 5 of 8'hA5.
        tick();
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        for (int g = 0; g < 5; g++) tick();
        check_eq("mid_load_before", 32'(load[0]), 32'd1);
        RST_N = 1'b0;
        #1;
        check_eq("mid_load_drop", 32'({load[0], busy[0]}), 32'd0);
        tick();
        tick();
        RST_N  = 1'b1;
        pulses = 0;
        for (int g = 0; g < 16; g++) begin
            if (rx_valid[0]) pulses++;
            tick();
        end
        check_eq("mid_no_rx_valid", 32'(pulses), 32'd0);
        run_word(0, 8'h5A, got, lat);
        check_eq("post_rst_latency", 32'(lat), 32'd13);
        check_eq("post_rst_rx_data", 32'(got), 32'h5A);

`ifdef SISO_LOOPBACK_CHECK_EN
        // Serial_OUT stuck at 1.
        tick();
        check_eq("lb_error_clear", 32'(error[0]), 32'd0);
        stuck[0] = 1'b1;
        run_word(0, 8'h0F, got, lat);
        check_eq("lb_stuck_rx_data", 32'(got), 32'hFF);
        check_eq("lb_mismatch", 32'(mismatch[0]), 32'd1);
        check_eq("lb_error", 32'(error[0]), 32'd1);
        tick();
        check_eq("lb_mismatch_pulse", 32'(mismatch[0]), 32'd0);
        check_eq("lb_error_sticky", 32'(error[0]), 32'd1);
        stuck[0] = 1'b0;
        run_word(0, 8'h33, got, lat);
        check_eq("lb_good_rx_data", 32'(got), 32'h33);
        check_eq("lb_good_mismatch", 32'(mismatch[0]), 32'd0);
        check_eq("lb_good_error", 32'(error[0]), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_shift_ctrl.md
Name: siso_shift_ctrl

Overview:
Sequencer that drives the 4-bit serial-in/serial-out shift register.
- Accepts a parallel word over a valid/ready handshake.
- Serialises the word into the register: drives Serial_IN and the shift enable Load.
- Flushes the register's pipeline depth, then reassembles the bits returned on Serial_OUT into a parallel word.
- Sits between a parallel producer/consumer and the shift register, which it owns exclusively.

Parameters:
- WIDTH, 8: bits per word. Legal range 1..32.
- DEPTH, 4: stages in the controlled shift register, equal to the Serial_IN-to-Serial_OUT latency in shift cycles. Legal range 1..16.
- MSB_FIRST, 1: 1 sends and reassembles the MSB first; 0 sends and reassembles the LSB first.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- Tx_Data  input  WIDTH  word to serialise.
- Tx_Valid  input  1  Tx_Data is valid.
- Tx_Ready  output  1  controller can accept a word.
- Serial_IN  output  1  bit to the shift register input.
- Load  output  1  shift enable to the shift register; the register shifts on every edge where it is 1.
- Serial_OUT  input  1  shift register output, equal to the last stage.
- Rx_Data  output  WIDTH  reassembled word.
- Rx_Valid  output  1  one-cycle pulse; Rx_Data is valid.
- Busy  output  1  a transfer is in progress.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values, all registered: state IDLE, Tx_Ready 0, Load 0, Serial_IN 0, Rx_Data 0, Rx_Valid 0, Busy 0, counter 0.
- Tx_Ready rises on the first CLK edge after RST_N deasserts.
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - Tx_Ready is 1.
  - On Tx_Valid and Tx_Ready at an edge: latch Tx_Data into the tx shift register, clear the counter, go to SHIFT. Tx_Ready drops and Busy rises at the same edge.
- SHIFT:
  - Lasts WIDTH cycles; counter c = 0..WIDTH-1.
  - Load is 1; Serial_IN carries word bit c in MSB_FIRST order.
  - After c = WIDTH-1, go to FLUSH.
- FLUSH:
  - Lasts DEPTH cycles.
  - Load is 1; Serial_IN is 0.
  - After the last FLUSH cycle, go to DONE.
- Global shift-cycle index g runs 0..WIDTH+DEPTH-1 across SHIFT and FLUSH.
- Capture:
  - In cycle g, Serial_OUT holds the bit driven at g-DEPTH.
  - Serial_OUT is sampled into the rx shift register at edges ending cycles g = DEPTH..WIDTH+DEPTH-1, exactly WIDTH samples.
  - Samples for g < DEPTH are stale register contents and are ignored.
  - When WIDTH < DEPTH, capture starts in FLUSH; this is legal.
- DONE:
  - One cycle. Rx_Valid is 1 and Rx_Data holds the reassembled word; Load is 0; Busy is 0.
  - Next state is IDLE.
  - Rx_Data holds its value until the next DONE.
- Latency: Rx_Valid is high in cycle WIDTH+DEPTH+1 after the accept edge.
- Throughput: one word per WIDTH+DEPTH+2 cycles.
- Rx_Valid has no backpressure.
- Tx_Valid without Tx_Ready is ignored; Tx_Data changes while Busy are ignored.
- Reset mid-transfer: immediate return to the reset values, Load 0 at once. The partial word is discarded and no Rx_Valid is produced. Shift register contents are left as they are; they are harmless because of the capture window.
- Counter width is $clog2(WIDTH+DEPTH+1). It never wraps within a transfer.

Optional Feature:
SISO_LOOPBACK_CHECK_EN
- Defined:
  - Adds output port Mismatch (1 bit, reset 0).
  - In DONE, Mismatch = (Rx_Data != latched Tx word), valid only while Rx_Valid is 1; 0 otherwise.
  - Adds a sticky output Error (reset 0), set on any Mismatch and cleared only by RST_N.
- Undefined: neither port exists and no compare logic is built.

Decomposition:
- Package siso_ctrl_pkg:
  - state enum (IDLE, SHIFT, FLUSH, DONE), 2-bit encoding;
  - default WIDTH/DEPTH constants;
  - function bit_sel(word, index, msb_first).
- One sub-module: siso_bit_counter, a loadable up-counter with terminal-count flags at WIDTH-1 and WIDTH+DEPTH-1, instanced once.
- The FSM, tx shifter and rx shifter stay in the top module.

Test Plan:
- Reset and handshake: RST_N low for 3 cycles, then high. All outputs are 0 during reset; Tx_Ready = 1 after the first edge.
- Basic word (WIDTH=8, DEPTH=4, MSB_FIRST=1): Tx_Data=8'hA5 accepted.
  - Serial_IN sequence is 1,0,1,0,0,1,0,1 then 0,0,0,0, with Load = 1 for 12 cycles.
  - Rx_Valid pulses 13 cycles after accept with Rx_Data = 8'hA5.
- LSB-first with back-to-back transfers (MSB_FIRST=0): words 8'h3C then 8'hF0 with Tx_Valid held high.
  - Second accept occurs in the IDLE cycle after DONE; spacing is 14 cycles.
  - Serial_IN for 8'h3C is 0,0,1,1,1,1,0,0.
  - Rx_Data is 8'h3C then 8'hF0.
- Stale contents ignored: preload the shift register with 4'b1111, then send 8'h00. Rx_Data = 8'h00.
- Reset mid-operation: RST_N low during SHIFT cycle 5 of 8'hA5.
  - Load drops in the same cycle; no Rx_Valid is produced.
  - A following 8'h5A completes correctly.
- With SISO_LOOPBACK_CHECK_EN: force Serial_OUT stuck at 1 and send 8'h0F.
  - Mismatch = 1 with Rx_Valid; Error stays 1.
  - A second word sent without the fault gives Mismatch = 0 and Error still 1.
